alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Accepts a decoded MIPS-subset instruction with register operands and applies single-level forwarding from the EX/MEM result.
- Generates the ALU's 32-bit a/b operands and 4-bit select s, and registers them behind a valid/ready handshake.
- Holds the instruction under downstream stall; supports flush for branch redirect.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU a/b/z width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  6  instruction [31:26].
- funct  input  6  instruction [5:0]; used only when opcode==0.
- imm  input  16  instruction [15:0].
- rs_idx  input  REG_IDX_W  source register index for operand a.
- rt_idx  input  REG_IDX_W  source register index for operand b.
- rd_idx  input  REG_IDX_W  R-type destination index.
- rs_data  input  DATA_W  register-file read of rs.
- rt_data  input  DATA_W  register-file read of rt.
- fwd_valid  input  1  EX/MEM result is a pending register write.
- fwd_idx  input  REG_IDX_W  EX/MEM destination index.
- fwd_data  input  DATA_W  EX/MEM result value.
- flush  input  1  kill the held and incoming instruction.
- out_valid  output  1  held instruction valid toward the ALU.
- out_ready  input  1  downstream accepts this cycle.
- alu_a  output  DATA_W  ALU operand a.
- alu_b  output  DATA_W  ALU operand b.
- alu_s  output  4  ALU select.
- dest_idx  output  REG_IDX_W  writeback destination.
- reg_write  output  1  instruction writes a register.
- illegal  output  1  present only with ILLEGAL_TRAP_EN.

Behaviour:
- Reset: when rst_n==0 at a clock edge, out_valid, alu_a, alu_b, alu_s, dest_idx, reg_write and illegal are all 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted on edge N appears on the outputs after edge N.
- Stall: while out_valid && !out_ready, every output is held stable.
- Flush: has priority over everything except reset. On a flush edge, out_valid goes to 0 and any simultaneous input is dropped.
- ALU select encoding: 0=add, 1=sub, 2=and, 3=or, 4=slt (signed compare). Values 5-15 are never produced.
- Decode, R-type (opcode 0x00), funct maps as:
  - 0x20 -> 0
  - 0x22 -> 1
  - 0x24 -> 2
  - 0x25 -> 3
  - 0x2A -> 4
  - R-type sets dest=rd_idx, b=rt operand, reg_write=1.
- Decode, I-type (b=immediate, dest=rt_idx):
  - addi 0x08 -> 0, sign-extended, reg_write=1.
  - slti 0x0A -> 4, sign-extended, reg_write=1.
  - andi 0x0C -> 2, zero-extended, reg_write=1.
  - ori 0x0D -> 3, zero-extended, reg_write=1.
  - lw 0x23 -> 0, sign-extended, reg_write=1.
  - sw 0x2B -> 0, sign-extended, reg_write=0.
- Decode, beq 0x04: select 1, b=rt operand, reg_write=0.
- Other opcode/funct values: select 0, reg_write=0, illegal=1.
- dest_idx==0 forces reg_write=0.
- Forwarding: rs operand = fwd_data if fwd_valid && fwd_idx==rs_idx && rs_idx!=0; otherwise rs_data. The rt operand uses the same rule. Forwarding is evaluated in the accept cycle only.
- Index 0 always reads as 0, regardless of rs_data/rt_data.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - The illegal port exists and is registered with the other outputs.
  - An illegal instruction is passed with out_valid=1, illegal=1, reg_write=0.
- ILLEGAL_TRAP_EN undefined:
  - No illegal port.
  - An illegal instruction is silently accepted and dropped: out_valid stays 0 and in_ready behaves normally.

Decomposition:
- Shared package alu_pkg:
  - Opcode and funct localparams.
  - ALU select constants (ALU_ADD=0 … ALU_SLT=4).
  - DATA_W default.
- One natural sub-module: alu_control, a purely combinational opcode/funct -> {alu_s, use_imm, zero_ext, dest_sel, reg_write, illegal} decoder. The stage instantiates it once.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0; after release, in_ready=1.
- R-type add: opcode=0, funct=0x20, rs_data=5, rt_data=7, rd_idx=3 -> next cycle alu_a=5, alu_b=7, alu_s=0, dest_idx=3, reg_write=1.
- I-type immediates:
  - andi imm=0xFFFF -> alu_b=0x0000FFFF, alu_s=2.
  - addi imm=0xFFFF -> alu_b=0xFFFFFFFF, alu_s=0.
  - sw -> reg_write=0.
- Forwarding:
  - fwd_valid=1, fwd_idx=4, fwd_data=0xDEAD, rs_idx=4, rt_idx=4, rs_data=1 -> alu_a=alu_b=0xDEAD.
  - Same with idx=0 -> alu_a=0.
- Stall/flush:
  - Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0.
  - Assert flush alongside in_valid -> out_valid=0 next cycle.
- Illegal: opcode=0x3F -> with ILLEGAL_TRAP_EN, out_valid=1 and illegal=1; without it, out_valid stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue stage: MIPS-subset opcode and funct
// values, ALU select encodings, destination-select type and default widths.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_REG_IDX_W = 5;

    // Primary opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction [5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU select encodings; values 5..15 are never produced.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // Which instruction field names the writeback register.
    typedef enum logic {
        DEST_RT = 1'b0,
        DEST_RD = 1'b1
    } dest_sel_e;

endpackage

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Purely combinational MIPS-subset decoder.
//   opcode, funct  : instruction fields (funct only meaningful for opcode 0)
//   alu_s          : ALU select
//   use_imm        : operand b comes from the immediate instead of rt
//   zero_ext       : immediate is zero-extended (else sign-extended)
//   dest_sel       : writeback index from rd (R-type) or rt
//   reg_write      : instruction writes a register (before the r0 override)
//   illegal        : opcode/funct not in the supported subset
// -----------------------------------------------------------------------------
module alu_control
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_s,
    output logic       use_imm,
    output logic       zero_ext,
    output dest_sel_e  dest_sel,
    output logic       reg_write,
    output logic       illegal
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        alu_s     = ALU_ADD;
        use_imm   = 1'b0;
        zero_ext  = 1'b0;
        dest_sel  = DEST_RT;
        reg_write = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dest_sel  = DEST_RD;
                reg_write = 1'b1;
                unique case (funct)
                    FN_ADD:  alu_s = ALU_ADD;
                    FN_SUB:  alu_s = ALU_SUB;
                    FN_AND:  alu_s = ALU_AND;
                    FN_OR:   alu_s = ALU_OR;
                    FN_SLT:  alu_s = ALU_SLT;
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin use_imm = 1'b1; reg_write = 1'b1; end
            OP_SLTI: begin use_imm = 1'b1; reg_write = 1'b1; alu_s = ALU_SLT; end
            OP_ANDI: begin use_imm = 1'b1; reg_write = 1'b1; zero_ext = 1'b1; alu_s = ALU_AND; end
            OP_ORI:  begin use_imm = 1'b1; reg_write = 1'b1; zero_ext = 1'b1; alu_s = ALU_OR; end
            OP_LW:   begin use_imm = 1'b1; reg_write = 1'b1; end
            OP_SW:   use_imm = 1'b1;
            OP_BEQ:  alu_s = ALU_SUB;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// ID/EX register stage in front of the ALU. Decodes the instruction, picks
// operands with single-level EX/MEM forwarding, and registers a/b/select and
// writeback info behind a valid/ready handshake (1-cycle latency).
//   in_valid/in_ready    : upstream handshake (in_ready = !out_valid || out_ready)
//   opcode/funct/imm     : instruction fields
//   rs/rt/rd_idx, *_data : register indices and register-file read data
//   fwd_valid/idx/data   : pending EX/MEM register write
//   flush                : kill held and incoming instruction
//   out_valid/out_ready  : downstream handshake
//   alu_a/alu_b/alu_s    : ALU operands and select
//   dest_idx/reg_write   : writeback target
//   illegal              : only when ILLEGAL_TRAP_EN is defined; without it an
//                          illegal instruction is accepted and dropped.
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int REG_IDX_W = DEFAULT_REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [15:0]          imm,
    input  logic [REG_IDX_W-1:0] rs_idx,
    input  logic [REG_IDX_W-1:0] rt_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [DATA_W-1:0]    rs_data,
    input  logic [DATA_W-1:0]    rt_data,
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_idx,
    input  logic [DATA_W-1:0]    fwd_data,
    input  logic                 flush,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_s,
    output logic [REG_IDX_W-1:0] dest_idx,
    output logic                 reg_write
);

    logic [3:0] dec_s;
    logic       dec_use_imm;
    logic       dec_zero_ext;
    dest_sel_e  dec_dest_sel;
    logic       dec_reg_write;
    logic       dec_illegal;

    alu_control u_alu_control (
        .opcode    (opcode),
        .funct     (funct),
        .alu_s     (dec_s),
        .use_imm   (dec_use_imm),
        .zero_ext  (dec_zero_ext),
        .dest_sel  (dec_dest_sel),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    // r0 reads as zero; otherwise a matching pending EX/MEM write wins.
    function automatic logic [DATA_W-1:0] read_operand(
        input logic [REG_IDX_W-1:0] idx,
        input logic [DATA_W-1:0]    rf_data
    );
        if (idx == '0)
            return '0;
        else if (fwd_valid && (fwd_idx == idx))
            return fwd_data;
        else
            return rf_data;
    endfunction

    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    rs_op;
    logic [DATA_W-1:0]    rt_op;
    logic [REG_IDX_W-1:0] dest_new;
    logic                 accept;

    assign imm_ext  = dec_zero_ext ? {{(DATA_W-16){1'b0}}, imm}
                                   : {{(DATA_W-16){imm[15]}}, imm};
    assign rs_op    = read_operand(rs_idx, rs_data);
    assign rt_op    = read_operand(rt_idx, rt_data);
    assign dest_new = (dec_dest_sel == DEST_RD) ? rd_idx : rt_idx;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [3:0]           alu_s_q, alu_s_d;
    logic [REG_IDX_W-1:0] dest_idx_q, dest_idx_d;
    logic                 reg_write_q, reg_write_d;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_q, illegal_d;
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        dest_idx_d  = dest_idx_q;
        reg_write_d = reg_write_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
`ifdef ILLEGAL_TRAP_EN
            out_valid_d = 1'b1;
            illegal_d   = dec_illegal;
`else
            // Illegal instructions are consumed but never presented.
            out_valid_d = !dec_illegal;
`endif
            alu_a_d     = rs_op;
            alu_b_d     = dec_use_imm ? imm_ext : rt_op;
            alu_s_d     = dec_s;
            dest_idx_d  = dest_new;
            reg_write_d = dec_reg_write && (dest_new != '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            dest_idx_q  <= '0;
            reg_write_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            dest_idx_q  <= dest_idx_d;
            reg_write_q <= reg_write_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign dest_idx  = dest_idx_q;
    assign reg_write = reg_write_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal   = illegal_q;
`endif

endmodule
